// File: rtl/slice_packer.sv
// Packs a stream of BUS_SIZE slices, slice 0 first, into one wide word and
// holds the finished word under valid/ready until the consumer takes it.
module slice_packer #(
  parameter  int BITS_ENABLES = 2,
  parameter  int BUS_SIZE     = 8,
  localparam int NUM_SLICES   = 2**BITS_ENABLES
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic [BUS_SIZE-1:0]            i_data,
  output logic                           o_ready,
  input  logic                           i_flush,
  output logic [NUM_SLICES*BUS_SIZE-1:0] o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [BITS_ENABLES-1:0]        o_count
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [BITS_ENABLES-1:0] LAST = BITS_ENABLES'(NUM_SLICES - 1);

  state_t                                  state, state_next;
  logic [NUM_SLICES-1:0][BUS_SIZE-1:0]     slices;
  logic [BITS_ENABLES-1:0]                 count;
  logic                                    accept;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= FILL;
    else         state <= state_next;
  end

  // Flush overrides the FSM; reset is handled in the state register.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    accept     = 1'b0;
    case (state)
      FILL: begin
        o_ready = 1'b1;
        accept  = i_valid && !i_flush;
        if (accept && count == LAST) state_next = FULL;
      end
      FULL: begin
        o_valid = 1'b1;
        if (i_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    if (i_flush) state_next = FILL;
  end

  // Buffer is never cleared on handoff; new slices overwrite in place.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      slices <= '0;
      count  <= '0;
    end else if (accept) begin
      slices[count] <= i_data;
      count         <= count + 1'b1;
    end
  end

  assign o_data  = slices;
  assign o_count = count;

endmodule

// File: doc/slice_packer.md
Name: slice_packer

Overview:
- Assembles a wide word from a stream of narrow slices, slice 0 first. It is the write-side counterpart of our indexed slice selector.
- Slice k lands at bits [k*BUS_SIZE +: BUS_SIZE], the same layout the selector reads with i_en = k.
- Used on the debug-unit receive path: bytes arrive from the UART RX and are packed into a 32-bit instruction/data word before the word is handed to program memory.
- Valid/ready on both sides. Output is held until the consumer accepts it.

Parameters:
- BITS_ENABLES, 2, width of the slice index.
- BUS_SIZE, 8, width of one slice in bits.
- NUM_SLICES, 2**BITS_ENABLES, slices per packed word (derived; do not override).

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream slice present on i_data.
- i_data  input  BUS_SIZE  incoming slice.
- o_ready  output  1  packer can accept a slice this cycle.
- i_flush  input  1  abort the partial word; synchronous.
- o_data  output  NUM_SLICES*BUS_SIZE  packed word.
- o_valid  output  1  packed word complete and stable.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_count  output  BITS_ENABLES  index of the next slice to be written.

Behaviour:
- Clock and reset: single clock domain, i_clk. i_reset is synchronous and active-high.
- Reset: state=FILL, o_data=0, o_valid=0, o_count=0, o_ready=1. Reset has priority over every other input.
- States (2-state FSM):
  - FILL: o_ready=1, o_valid=0.
  - FULL: o_ready=0, o_valid=1.
- FILL, slice accept: when i_valid=1 (o_ready is 1), write i_data into slice o_count of the buffer; o_count <= o_count+1.
- FILL, last slice: if o_count==NUM_SLICES-1 on accept, o_count wraps to 0 and the state goes to FULL.
- FILL, no input: with i_valid=0, nothing changes.
- FULL, hold: o_data is held constant; i_valid is ignored (no accept because o_ready=0).
- FULL, handoff: on i_ready=1, next state is FILL.
- Latency:
  - o_valid rises the cycle after the last slice is accepted.
  - After a consumer accept, o_ready rises the next cycle.
  - Throughput is at most one word per NUM_SLICES+1 cycles. There is no same-cycle bypass from FULL to a new accept.
- Buffer reuse: the buffer is not cleared on handoff. New slices overwrite old ones in place. Slices not yet rewritten keep their previous values (only visible through o_data while in FILL; o_data is valid only while o_valid=1).
- i_flush (priority below i_reset, above everything else):
  - next state=FILL, o_count=0, o_data=0, o_valid=0.
  - A slice offered in the same cycle is dropped.
- i_flush in FULL together with i_ready: the consumer transfer in that cycle counts as completed (the consumer sampled o_data), and the flush is still applied.
- Reset or flush mid-word: all partial slices are discarded. No partial word is ever presented with o_valid=1.
- Width rule: o_count is BITS_ENABLES bits and wraps naturally at NUM_SLICES. No other arithmetic.

Test Plan:
- Reset, then i_valid=1 with bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles, i_ready=0 → o_valid=1 the cycle after 0x44, o_data=0x44332211, o_ready=0. Output is held for 5 more cycles with i_valid=1 and i_data=0xFF (no change).
- From the FULL state above, pulse i_ready=1 for 1 cycle → next cycle o_valid=0, o_ready=1, o_count=0. Then feed 0xAA,0xBB,0xCC,0xDD → o_data=0xDDCCBBAA.
- Gappy input: i_valid toggling 1,0,0,1,0,1,1 with slices 0x01..0x04 → o_count steps 1,1,1,2,2,3,0, then o_data=0x04030201, o_valid=1.
- Flush: after 2 slices (0x55,0x66), assert i_flush with i_valid=1 and i_data=0x77 → o_count=0, o_data=0, 0x77 dropped. Then 4 more slices 0x01..0x04 → o_data=0x04030201.
- Reset mid-word: i_reset asserted after 3 slices, simultaneous with i_valid → all outputs return to reset values. A following 4-slice sequence packs correctly.
- Parameter sweep BITS_ENABLES=1, BUS_SIZE=16: slices 0xBEEF then 0xDEAD → o_data=0xDEADBEEF, o_valid=1 after 2 accepts.
